// File: rtl/ctrl_conv_seq_pkg.sv
// conv_pkg: shared types and helpers for the 1-D convolution controller.
// Holds the controller state encoding, the output-count helper and an
// address-width helper that never returns zero.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        CAPTURE,
        OUT,
        DONE
    } ctrl_conv_state_t;

    // Number of complete windows; a trailing partial window is dropped.
    function automatic int n_out_f(input int x, input int f, input int s);
        return (x - f) / s + 1;
    endfunction

    // Address width for a memory of n entries, at least one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : conv_pkg

// File: rtl/ctrl_delay_line.sv
// ctrl_delay_line: fixed-depth shift line that aligns the read strobe and
// the first-tap flag with the memory read latency. A synchronous clear
// flushes in-flight entries when the controller aborts a convolution.
module ctrl_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift the strobe/flag pair one stage per cycle, flushing on clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every stage is reset here because these are control
            // strobes; a stale 1 left over from reset would fire a bogus
            // accumulate. Wide datapath arrays would normally stay unreset.
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_dout = r_pipe[DEPTH-1];

endmodule : ctrl_delay_line

// File: rtl/ctrl_conv_seq.sv
// ctrl_conv_seq: controller for the 1-D convolution engine.
// Sequences window reads from the X and F memories, aligns the MAC
// accumulate strobes with the read latency, captures each finished sum and
// runs the valid/ready handshake on y.
// Build option: define CTRL_CONV_OVERLAP_EN to let the next window fetch
// while the previous y is still waiting for its handshake.
module ctrl_conv_seq
    import conv_pkg::*;
#(
    parameter int X_MEM_SIZE       = 8,
    parameter int F_MEM_SIZE       = 4,
    parameter int STRIDE           = 1,
    parameter int RD_LAT           = 1,
    parameter int X_MEM_ADDR_WIDTH = addr_w(X_MEM_SIZE),
    parameter int F_MEM_ADDR_WIDTH = addr_w(F_MEM_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        conv_start,
    input  logic                        m_ready_y,
    output logic [X_MEM_ADDR_WIDTH-1:0] xmem_addr,
    output logic [F_MEM_ADDR_WIDTH-1:0] fmem_addr,
    output logic                        mem_rd_en,
    output logic                        accum_en,
    output logic                        accum_clr,
    output logic                        y_capture,
    output logic                        m_valid_y,
    output logic                        conv_done,
    output logic                        busy
);

    localparam int N_OUT = n_out_f(X_MEM_SIZE, F_MEM_SIZE, STRIDE);
    localparam int NW    = addr_w(N_OUT);
    localparam int DW    = $clog2(RD_LAT + 1);

    localparam logic [F_MEM_ADDR_WIDTH-1:0] K_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_STEP = X_MEM_ADDR_WIDTH'(STRIDE);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_ONE  = X_MEM_ADDR_WIDTH'(1);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] F_ONE  = F_MEM_ADDR_WIDTH'(1);
    localparam logic [NW-1:0]               N_LAST = NW'(N_OUT - 1);
    localparam logic [NW-1:0]               N_ONE  = NW'(1);
    localparam logic [DW-1:0]               D_LAST = DW'(RD_LAT - 1);
    localparam logic [DW-1:0]               D_ONE  = DW'(1);

    ctrl_conv_state_t            r_state;
    logic [X_MEM_ADDR_WIDTH-1:0] r_base;
    logic [NW-1:0]               r_n_out;
    logic [DW-1:0]               r_drain_cnt;
    logic [X_MEM_ADDR_WIDTH-1:0] r_xmem_addr;
    logic [F_MEM_ADDR_WIDTH-1:0] r_fmem_addr;
    logic                        r_mem_rd_en;
    logic                        r_m_valid_y;
    logic                        r_conv_done;
    logic                        r_busy;

    logic       w_abort;
    logic       w_cap_ok;
    logic       w_y_capture;
    logic       w_handshake;
    logic [1:0] w_dl_in;
    logic [1:0] w_dl_out;

    // Dropping conv_start mid-run abandons the convolution; IDLE and DONE
    // are the two states where a low conv_start is the normal exit path.
    assign w_abort = !conv_start && (r_state != IDLE) && (r_state != DONE);

`ifdef CTRL_CONV_OVERLAP_EN
    // A new y may only be captured once the previous one has been taken,
    // or is being taken this very cycle.
    assign w_cap_ok = !r_m_valid_y || m_ready_y;
`else
    assign w_cap_ok = 1'b1;
`endif

    // NOTE: y_capture is decoded combinationally from the state register
    // because in overlap mode it depends on this cycle's m_ready_y; a
    // registered version would be one cycle late and could overwrite y.
    assign w_y_capture = (r_state == CAPTURE) && w_cap_ok && !w_abort;
    assign w_handshake = r_m_valid_y && m_ready_y;

    // The first tap of every window is flagged so the MAC loads instead of adds.
    assign w_dl_in = {r_mem_rd_en, r_mem_rd_en && (r_fmem_addr == '0)};

    ctrl_delay_line #(
        .DEPTH (RD_LAT),
        .WIDTH (2)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_abort),
        .i_din   (w_dl_in),
        .o_dout  (w_dl_out)
    );

    // y valid flag: set by a capture, cleared by the handshake, so a
    // simultaneous clear and set leaves it high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_valid_y <= 1'b0;
        end else if (w_abort) begin
            r_m_valid_y <= 1'b0;
        end else if (w_y_capture) begin
            r_m_valid_y <= 1'b1;
        end else if (w_handshake) begin
            r_m_valid_y <= 1'b0;
        end
    end

    // Main sequencer: state, window/tap counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_n_out     <= '0;
            r_drain_cnt <= '0;
            r_xmem_addr <= '0;
            r_fmem_addr <= '0;
            r_mem_rd_en <= 1'b0;
            r_conv_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            if (w_abort) begin
                r_state     <= IDLE;
                r_mem_rd_en <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (conv_start) begin
                            r_state     <= FETCH;
                            r_busy      <= 1'b1;
                            r_mem_rd_en <= 1'b1;
                            r_base      <= '0;
                            r_n_out     <= '0;
                            r_xmem_addr <= '0;
                            r_fmem_addr <= '0;
                        end
                    end

                    FETCH: begin
                        if (r_fmem_addr == K_LAST) begin
                            r_mem_rd_en <= 1'b0;
                            r_drain_cnt <= '0;
                            r_state     <= DRAIN;
                        end else begin
                            r_fmem_addr <= r_fmem_addr + F_ONE;
                            r_xmem_addr <= r_xmem_addr + X_ONE;
                        end
                    end

                    DRAIN: begin
                        if (r_drain_cnt == D_LAST) begin
                            r_state <= CAPTURE;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + D_ONE;
                        end
                    end

                    CAPTURE: begin
                        if (w_cap_ok) begin
                            r_base <= r_base + X_STEP;
`ifdef CTRL_CONV_OVERLAP_EN
                            if (r_n_out == N_LAST) begin
                                r_state <= OUT;
                            end else begin
                                r_n_out     <= r_n_out + N_ONE;
                                r_state     <= FETCH;
                                r_mem_rd_en <= 1'b1;
                                r_xmem_addr <= r_base + X_STEP;
                                r_fmem_addr <= '0;
                            end
`else
                            r_state <= OUT;
`endif
                        end
                    end

                    OUT: begin
                        if (w_handshake) begin
`ifdef CTRL_CONV_OVERLAP_EN
                            r_state     <= DONE;
                            r_conv_done <= 1'b1;
`else
                            if (r_n_out == N_LAST) begin
                                r_state     <= DONE;
                                r_conv_done <= 1'b1;
                            end else begin
                                r_n_out     <= r_n_out + N_ONE;
                                r_state     <= FETCH;
                                r_mem_rd_en <= 1'b1;
                                r_xmem_addr <= r_base;
                                r_fmem_addr <= '0;
                            end
`endif
                        end
                    end

                    DONE: begin
                        if (!conv_start) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end

                    default: begin
                        r_state     <= IDLE;
                        r_mem_rd_en <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign xmem_addr = r_xmem_addr;
    assign fmem_addr = r_fmem_addr;
    assign mem_rd_en = r_mem_rd_en;
    assign accum_en  = w_dl_out[1];
    assign accum_clr = w_dl_out[0];
    assign y_capture = w_y_capture;
    assign m_valid_y = r_m_valid_y;
    assign conv_done = r_conv_done;
    assign busy      = r_busy;

endmodule : ctrl_conv_seq

// File: tb/tb_ctrl_conv_seq.sv
// tb_ctrl_conv_seq: directed bench for ctrl_conv_seq (default build).
// Three instances cover X=8/F=4/S=1/L=1, X=9/F=3/S=2/L=2 and the F=X case.
module tb_ctrl_conv_seq;

    localparam int HN   = 80;
    localparam int RD   = 0;
    localparam int AEN  = 1;
    localparam int CLR  = 2;
    localparam int CAP  = 3;
    localparam int VAL  = 4;
    localparam int DONE = 5;
    localparam int BUSY = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic conv_start;
    logic m_ready_y;
    int   sel;
    int   stall_lo, stall_hi, abort_at;

    logic st_a, st_b, st_c;
    assign st_a = (sel == 0) && conv_start;
    assign st_b = (sel == 1) && conv_start;
    assign st_c = (sel == 2) && conv_start;

    logic [2:0] a_x; logic [1:0] a_f;
    logic a_rd, a_aen, a_clr, a_cap, a_val, a_done, a_busy;
    logic [3:0] b_x; logic [1:0] b_f;
    logic b_rd, b_aen, b_clr, b_cap, b_val, b_done, b_busy;
    logic [1:0] c_x; logic [1:0] c_f;
    logic c_rd, c_aen, c_clr, c_cap, c_val, c_done, c_busy;

    ctrl_conv_seq #(.X_MEM_SIZE(8), .F_MEM_SIZE(4), .STRIDE(1), .RD_LAT(1)) u_a (
        .clk(clk), .reset_n(reset_n), .conv_start(st_a), .m_ready_y(m_ready_y),
        .xmem_addr(a_x), .fmem_addr(a_f), .mem_rd_en(a_rd), .accum_en(a_aen),
        .accum_clr(a_clr), .y_capture(a_cap), .m_valid_y(a_val),
        .conv_done(a_done), .busy(a_busy));

    ctrl_conv_seq #(.X_MEM_SIZE(9), .F_MEM_SIZE(3), .STRIDE(2), .RD_LAT(2)) u_b (
        .clk(clk), .reset_n(reset_n), .conv_start(st_b), .m_ready_y(m_ready_y),
        .xmem_addr(b_x), .fmem_addr(b_f), .mem_rd_en(b_rd), .accum_en(b_aen),
        .accum_clr(b_clr), .y_capture(b_cap), .m_valid_y(b_val),
        .conv_done(b_done), .busy(b_busy));

    ctrl_conv_seq #(.X_MEM_SIZE(4), .F_MEM_SIZE(4), .STRIDE(1), .RD_LAT(1)) u_c (
        .clk(clk), .reset_n(reset_n), .conv_start(st_c), .m_ready_y(m_ready_y),
        .xmem_addr(c_x), .fmem_addr(c_f), .mem_rd_en(c_rd), .accum_en(c_aen),
        .accum_clr(c_clr), .y_capture(c_cap), .m_valid_y(c_val),
        .conv_done(c_done), .busy(c_busy));

    // Observed signals of the selected instance.
    logic [3:0] o_x;
    logic [1:0] o_f;
    logic [6:0] o_bits;  // {rd, aen, clr, cap, val, done, busy}
    always_comb begin
        o_x    = '0;
        o_f    = '0;
        o_bits = '0;
        case (sel)
            0: begin o_x = {1'b0, a_x}; o_f = a_f; o_bits = {a_rd, a_aen, a_clr, a_cap, a_val, a_done, a_busy}; end
            1: begin o_x = b_x;         o_f = b_f; o_bits = {b_rd, b_aen, b_clr, b_cap, b_val, b_done, b_busy}; end
            2: begin o_x = {2'b0, c_x}; o_f = c_f; o_bits = {c_rd, c_aen, c_clr, c_cap, c_val, c_done, c_busy}; end
            default: ;
        endcase
    end

    int h_sig [7][HN];
    int h_x [HN];
    int h_f [HN];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Cycle -1: raise conv_start; the next rising edge enters FETCH (cycle 0).
    task automatic start_run(output int busy_before);
        @(negedge clk);
        conv_start  = 1'b1;
        m_ready_y   = 1'b1;
        #1;
        busy_before = int'(o_bits[0]);
    endtask

    // Record n cycles starting at cycle 0, applying the ready/abort plan.
    task automatic run(input int n);
        for (int t = 0; t < HN; t++) begin
            for (int s = 0; s < 7; s++) h_sig[s][t] = 0;
            h_x[t] = 0;
            h_f[t] = 0;
        end
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            m_ready_y = !(t >= stall_lo && t <= stall_hi);
            if (t == abort_at) conv_start = 1'b0;
            #1;
            for (int s = 0; s < 7; s++) h_sig[s][t] = int'(o_bits[6-s]);
            h_x[t] = int'(o_x);
            h_f[t] = int'(o_f);
        end
    endtask

    task automatic stop_run(input string tag);
        @(negedge clk);
        conv_start = 1'b0;
        m_ready_y  = 1'b1;
        @(negedge clk);
        #1;
        check(tag, int'(o_bits[0]), 0);
    endtask

    function automatic int cnt(input int which, input int a, input int b);
        int c = 0;
        for (int t = a; t <= b; t++) c += h_sig[which][t];
        return c;
    endfunction

    function automatic int nth(input int which, input int n);
        int seen = 0;
        for (int t = 0; t < HN; t++) begin
            if (h_sig[which][t] != 0) begin
                if (seen == n) return t;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int nth_base(input int n);
        int seen = 0;
        for (int t = 0; t < HN; t++) begin
            if (h_sig[RD][t] != 0 && h_f[t] == 0) begin
                if (seen == n) return h_x[t];
                seen++;
            end
        end
        return -1;
    endfunction

    initial begin
        int bb;
        int lag_bad;
        int found;

        reset_n    = 1'b0;
        conv_start = 1'b0;
        m_ready_y  = 1'b1;
        sel        = 0;
        stall_lo   = -1;
        stall_hi   = -2;
        abort_at   = -1;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", int'({o_x, o_f, o_bits}), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // X=8 F=4 S=1 L=1, ready always high: 5 outputs, period 7.
        sel = 0;
        start_run(bb);
        check("t1_busy_before_fetch", bb, 0);
        run(45);
        check("t1_busy_cycle0", h_sig[BUSY][0], 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1_capture%0d", i), nth(CAP, i), 5 + 7 * i);
            check($sformatf("t1_base%0d", i), nth_base(i), i);
        end
        check("t1_capture_count", cnt(CAP, 0, 44), 5);
        check("t1_first_valid", nth(VAL, 0), 6);
        check("t1_accum_en_count", cnt(AEN, 0, 44), 20);
        check("t1_accum_clr_count", cnt(CLR, 0, 44), 5);
        check("t1_done_cycle", nth(DONE, 0), 35);
        check("t1_done_count", cnt(DONE, 0, 44), 1);
        check("t1_done_holds_busy", h_sig[BUSY][44], 1);
        stop_run("t1_idle_after_stop");

        // X=9 F=3 S=2 L=2: 4 outputs at bases 0,2,4,6, accum lag 2.
        sel = 1;
        start_run(bb);
        run(40);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_capture%0d", i), nth(CAP, i), 5 + 7 * i);
            check($sformatf("t2_base%0d", i), nth_base(i), 2 * i);
        end
        check("t2_first_accum_en", nth(AEN, 0), 2);
        lag_bad = 0;
        for (int t = 2; t < 40; t++) begin
            if (h_sig[AEN][t] != h_sig[RD][t-2]) lag_bad++;
            if (h_sig[CLR][t] != int'(h_sig[RD][t-2] != 0 && h_f[t-2] == 0)) lag_bad++;
        end
        check("t2_lag_mismatches", lag_bad, 0);
        check("t2_accum_en_count", cnt(AEN, 0, 39), 12);
        check("t2_accum_clr_count", cnt(CLR, 0, 39), 4);
        check("t2_done_cycle", nth(DONE, 0), 28);
        stop_run("t2_idle_after_stop");

        // Stall at the 2nd output: ready low for cycles 13..22.
        sel      = 0;
        stall_lo = 13;
        stall_hi = 22;
        start_run(bb);
        run(55);
        stall_lo = -1;
        stall_hi = -2;
        check("t3_valid_during_stall", cnt(VAL, 13, 23), 11);
        check("t3_no_read_during_stall", cnt(RD, 13, 23), 0);
        check("t3_no_capture_during_stall", cnt(CAP, 13, 23), 0);
        check("t3_third_capture", nth(CAP, 2), 29);
        check("t3_done_cycle", nth(DONE, 0), 45);
        stop_run("t3_idle_after_stop");

        // Abort mid-FETCH of window 2 (cycle 8), then restart.
        sel      = 0;
        abort_at = 8;
        start_run(bb);
        run(20);
        abort_at = -1;
        check("t4_read_before_abort", h_sig[RD][8], 1);
        check("t4_busy_after_abort", h_sig[BUSY][9], 0);
        check("t4_read_after_abort", h_sig[RD][9], 0);
        check("t4_accum_flushed", h_sig[AEN][9], 0);
        check("t4_valid_after_abort", h_sig[VAL][9], 0);
        check("t4_no_done", cnt(DONE, 0, 19), 0);
        check("t4_no_reads_later", cnt(RD, 9, 19), 0);
        start_run(bb);
        run(12);
        check("t4_restart_base", nth_base(0), 0);
        check("t4_restart_capture", nth(CAP, 0), 5);
        stop_run("t4_idle_after_stop");

        // Asynchronous reset while waiting in OUT.
        sel = 0;
        start_run(bb);
        m_ready_y = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            #1;
            if (o_bits[2]) found = 1;
        end
        check("t5_valid_before_reset", found, 1);
        reset_n = 1'b0;
        #1;
        check("t5_outputs_async_reset", int'({o_x, o_f, o_bits}), 0);
        conv_start = 1'b0;
        m_ready_y  = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("t5_idle_after_release", int'({o_x, o_f, o_bits}), 0);

        // F = X: one output, DONE holds while conv_start stays high.
        sel = 2;
        start_run(bb);
        run(30);
        check("t6_capture_count", cnt(CAP, 0, 29), 1);
        check("t6_capture_cycle", nth(CAP, 0), 5);
        check("t6_done_cycle", nth(DONE, 0), 7);
        check("t6_done_count", cnt(DONE, 0, 29), 1);
        check("t6_read_count", cnt(RD, 0, 29), 4);
        check("t6_done_holds_busy", h_sig[BUSY][29], 1);
        stop_run("t6_idle_after_stop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ctrl_conv_seq
